// File: rtl/sum_window_averager.sv
// Windowed statistics stage: groups the adder's sum stream into blocks of 2**LOG2_N
// samples and emits truncated mean, min and max through a one-deep valid/ready register.
module sum_window_averager #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned LOG2_N = 3
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_avg,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [LOG2_N-1:0] win_count
);

    localparam int unsigned N     = 1 << LOG2_N;
    localparam int unsigned ACC_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST = LOG2_N'(N - 1);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] min_next;
    logic [DATA_W-1:0] max_next;
    logic              closing;
    logic              accept;

    assign acc_sum  = acc + ACC_W'(in_sum);
    assign min_next = (in_sum < run_min) ? in_sum : run_min;
    assign max_next = (in_sum > run_max) ? in_sum : run_max;
    assign closing  = (win_count == LAST);

    // Only the window-closing sample waits on a held result; clear blocks intake.
    assign in_ready = !clear && !(closing && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    // Running window accumulation and output register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            win_count <= '0;
            run_min   <= '1;
            run_max   <= '0;
            out_valid <= 1'b0;
            out_avg   <= '0;
            out_min   <= '0;
            out_max   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (clear) begin
                acc       <= '0;
                win_count <= '0;
                run_min   <= '1;
                run_max   <= '0;
            end else if (accept) begin
                if (closing) begin
                    // Result register is free here, so a same-cycle drain reloads it.
                    out_avg   <= acc_sum[ACC_W-1:LOG2_N];
                    out_min   <= min_next;
                    out_max   <= max_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    win_count <= '0;
                    run_min   <= '1;
                    run_max   <= '0;
                end else begin
                    acc       <= acc_sum;
                    win_count <= win_count + LOG2_N'(1);
                    run_min   <= min_next;
                    run_max   <= max_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_sum_window_averager.sv
// Directed bench for sum_window_averager: a driver pushes hand-computed window results
// into a queue and a monitor pops them whenever the output handshake fires.
module tb_sum_window_averager;

    logic       clock = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_sum;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_avg;
    logic [9:0] out_min;
    logic [9:0] out_max;
    logic [2:0] win_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [9:0] avg;
        logic [9:0] mn;
        logic [9:0] mx;
    } result_t;

    result_t exp_q[$];

    sum_window_averager #(.DATA_W(10), .LOG2_N(3)) dut (
        .clock     (clock),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_avg   (out_avg),
        .out_min   (out_min),
        .out_max   (out_max),
        .win_count (win_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_win(input int avg, input int mn, input int mx);
        result_t r;
        r.avg = 10'(avg);
        r.mn  = 10'(mn);
        r.mx  = 10'(mx);
        exp_q.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge after the sample was accepted.
    task automatic send(input int v);
        int t = 0;
        in_valid = 1'b1;
        in_sum   = 10'(v);
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clock);
            #1;
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Monitor: compare each result as the consumer takes it.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    result_t r;
                    r = exp_q.pop_front();
                    check("out_avg", int'(out_avg), int'(r.avg));
                    check("out_min", int'(out_min), int'(r.mn));
                    check("out_max", int'(out_max), int'(r.mx));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_win_count", int'(win_count), 0);
        check("rst_out_avg", int'(out_avg), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        @(negedge clock);

        // 1: constant window, single-cycle result
        expect_win(100, 100, 100);
        for (int i = 0; i < 8; i++) send(100);
        check("t1_valid_after_close", int'(out_valid), 1);
        @(negedge clock);
        check("t1_valid_dropped", int'(out_valid), 0);

        // 2: ramp with truncated mean
        expect_win(3, 0, 7);
        for (int i = 0; i < 8; i++) send(i);
        check("t2_win_count", int'(win_count), 0);
        @(negedge clock);

        // 3: largest adder sums, no accumulator overflow
        expect_win(765, 765, 765);
        for (int i = 0; i < 8; i++) send(765);
        @(negedge clock);

        // 4: held result stalls only the closing sample
        out_ready = 1'b0;
        expect_win(10, 10, 10);
        expect_win(20, 20, 20);
        fork
            begin
                for (int i = 0; i < 8; i++) send(10);
                for (int i = 0; i < 8; i++) send(20);
            end
            begin
                int t = 0;
                while (!(win_count == 3'd7 && out_valid && in_valid) && t < 100) begin
                    @(negedge clock);
                    #1;
                    t++;
                end
                check("t4_reached_stall", int'(win_count == 3'd7 && out_valid), 1);
                repeat (3) begin
                    @(negedge clock);
                    #1;
                    check("t4_in_ready_stalled", int'(in_ready), 0);
                    check("t4_avg_held", int'(out_avg), 10);
                end
                @(negedge clock);
                out_ready = 1'b1;
            end
        join
        repeat (2) @(negedge clock);

        // 5: clear aborts the partial window and refuses the same-cycle sample
        for (int i = 0; i < 4; i++) send(50);
        check("t5_partial_count", int'(win_count), 4);
        clear = 1'b1; in_valid = 1'b1; in_sum = 10'd50;
        #1;
        check("t5_in_ready_clear", int'(in_ready), 0);
        @(negedge clock);
        clear = 1'b0; in_valid = 1'b0;
        check("t5_count_cleared", int'(win_count), 0);
        expect_win(8, 8, 8);
        for (int i = 0; i < 8; i++) send(8);
        @(negedge clock);

        // 6: async reset discards pending result and partial window
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(40);
        for (int i = 0; i < 5; i++) send(60);
        check("t6_pending_avg", int'(out_avg), 40);
        check("t6_pending_count", int'(win_count), 5);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", int'(out_valid), 0);
        check("t6_rst_avg", int'(out_avg), 0);
        check("t6_rst_min", int'(out_min), 0);
        check("t6_rst_max", int'(out_max), 0);
        check("t6_rst_count", int'(win_count), 0);
        @(negedge clock);
        rst = 1'b0;
        out_ready = 1'b1;
        expect_win(4, 1, 8);
        for (int i = 1; i <= 8; i++) send(i);

        repeat (4) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
